// File: rtl/enc_b_t_1.sv
// Binary-to-temporal (race-logic) encoder: one rising edge per channel at the gamma tick equal to its value.
// Optional macro ENC_PULSE_OUT_EN: emit PULSE_WIDTH-cycle pulses clipped at the gamma boundary instead of steps.
module enc_b_t_1 #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CHANNELS      = 16,
    parameter int INPUT_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                                aclk,
    input  logic                                grst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0] in_values,
    input  logic [NUM_CHANNELS-1:0]             in_mask,
    output logic [NUM_CHANNELS-1:0]             out,
    output logic                                gamma_start,
    output logic                                active
);

    localparam int G_W   = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
    localparam int SUM_W = INPUT_WIDTH + $clog2(PULSE_WIDTH) + 1;
    localparam int CMP_W = ((SUM_W > G_W) ? SUM_W : G_W) + 1;

    localparam logic [G_W-1:0]   G_LAST = G_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CMP_W-1:0] GCW_C  = CMP_W'(GAMMA_CYCLE_WIDTH);

    logic [G_W-1:0] g_r;
    logic [G_W-1:0] g_nxt_s;
    logic           wrap_s;
    logic           accept_s;

    logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] in_vec_s;

    logic                                     staged_full_r;
    logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] staged_val_r;
    logic [NUM_CHANNELS-1:0]                  staged_mask_r;
    logic                                     staged_full_nxt_s;
    logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] staged_val_nxt_s;
    logic [NUM_CHANNELS-1:0]                  staged_mask_nxt_s;

    logic                                     active_valid_r;
    logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] active_val_r;
    logic [NUM_CHANNELS-1:0]                  active_mask_r;
    logic                                     active_valid_nxt_s;
    logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] active_val_nxt_s;
    logic [NUM_CHANNELS-1:0]                  active_mask_nxt_s;

    logic [CMP_W-1:0]                    g_cmp_s;
    logic [NUM_CHANNELS-1:0][CMP_W-1:0]  val_cmp_s;
    logic [NUM_CHANNELS-1:0]             pulse_ok_s;
    logic [NUM_CHANNELS-1:0]             out_nxt_s;

    logic [NUM_CHANNELS-1:0] out_r;
    logic                    in_ready_r;
    logic                    gamma_start_r;

    assign in_vec_s = in_values;
    assign wrap_s   = (g_r == G_LAST);
    // in_ready mirrors !staged_full, so the handshake never depends on in_valid.
    assign accept_s = in_valid && !staged_full_r;

    // Gamma counter next state; explicit compare keeps non-power-of-2 lengths correct.
    always_comb begin
        g_nxt_s = g_r;
        if (wrap_s) begin
            g_nxt_s = {G_W{1'b0}};
        end else begin
            g_nxt_s = g_r + G_W'(1);
        end
    end

    // Staging / active vector update: ACTIVE only ever changes on the boundary edge.
    always_comb begin
        staged_full_nxt_s  = staged_full_r;
        staged_val_nxt_s   = staged_val_r;
        staged_mask_nxt_s  = staged_mask_r;
        active_valid_nxt_s = active_valid_r;
        active_val_nxt_s   = active_val_r;
        active_mask_nxt_s  = active_mask_r;
        if (wrap_s) begin
            if (staged_full_r) begin
                active_valid_nxt_s = 1'b1;
                active_val_nxt_s   = staged_val_r;
                active_mask_nxt_s  = staged_mask_r;
                staged_full_nxt_s  = 1'b0;
            end else if (accept_s) begin
                active_valid_nxt_s = 1'b1;
                active_val_nxt_s   = in_vec_s;
                active_mask_nxt_s  = in_mask;
            end else begin
                active_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                staged_full_nxt_s = 1'b1;
                staged_val_nxt_s  = in_vec_s;
                staged_mask_nxt_s = in_mask;
            end else begin
                staged_full_nxt_s = staged_full_r;
            end
        end
    end

    // Widen counter and values so that value + PULSE_WIDTH - 1 cannot overflow.
    always_comb begin
        g_cmp_s   = CMP_W'(g_nxt_s);
        val_cmp_s = {NUM_CHANNELS*CMP_W{1'b0}};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            val_cmp_s[i] = CMP_W'(active_val_nxt_s[i]);
        end
    end

`ifdef ENC_PULSE_OUT_EN
    localparam logic [CMP_W-1:0] PW_M1_C = CMP_W'(PULSE_WIDTH - 1);

    // Pulse end limit; g never exceeds GAMMA_CYCLE_WIDTH-1, so pulses clip at the boundary.
    always_comb begin
        pulse_ok_s = {NUM_CHANNELS{1'b0}};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (g_cmp_s <= (val_cmp_s[i] + PW_M1_C)) begin
                pulse_ok_s[i] = 1'b1;
            end else begin
                pulse_ok_s[i] = 1'b0;
            end
        end
    end
`else
    // Step mode: an edge stays high until the next gamma boundary.
    always_comb begin
        pulse_ok_s = {NUM_CHANNELS{1'b1}};
    end
`endif

    // Output next state from next-state g and ACTIVE so out is aligned with g.
    always_comb begin
        out_nxt_s = {NUM_CHANNELS{1'b0}};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (active_valid_nxt_s && active_mask_nxt_s[i] && (val_cmp_s[i] < GCW_C) &&
                (g_cmp_s >= val_cmp_s[i]) && pulse_ok_s[i]) begin
                out_nxt_s[i] = 1'b1;
            end else begin
                out_nxt_s[i] = 1'b0;
            end
        end
    end

    // Counter and vector storage.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            g_r            <= {G_W{1'b0}};
            staged_full_r  <= 1'b0;
            staged_val_r   <= {NUM_CHANNELS*INPUT_WIDTH{1'b0}};
            staged_mask_r  <= {NUM_CHANNELS{1'b0}};
            active_valid_r <= 1'b0;
            active_val_r   <= {NUM_CHANNELS*INPUT_WIDTH{1'b0}};
            active_mask_r  <= {NUM_CHANNELS{1'b0}};
        end else begin
            g_r            <= g_nxt_s;
            staged_full_r  <= staged_full_nxt_s;
            staged_val_r   <= staged_val_nxt_s;
            staged_mask_r  <= staged_mask_nxt_s;
            active_valid_r <= active_valid_nxt_s;
            active_val_r   <= active_val_nxt_s;
            active_mask_r  <= active_mask_nxt_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            out_r         <= {NUM_CHANNELS{1'b0}};
            in_ready_r    <= 1'b1;
            gamma_start_r <= 1'b1;
        end else begin
            out_r         <= out_nxt_s;
            in_ready_r    <= !staged_full_nxt_s;
            gamma_start_r <= (g_nxt_s == {G_W{1'b0}});
        end
    end

    assign out         = out_r;
    assign in_ready    = in_ready_r;
    assign gamma_start = gamma_start_r;
    assign active      = active_valid_r;

endmodule

// File: tb/tb_enc_b_t_1.sv
// Scoreboard bench for enc_b_t_1 (GAMMA=16, 4 channels); pulse-mode expectations follow ENC_PULSE_OUT_EN.
module tb_enc_b_t_1;

    logic        aclk;
    logic        grst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_values;
    logic [3:0]  in_mask;
    logic [3:0]  out;
    logic        gamma_start;
    logic        active;

    enc_b_t_1 #(
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH(4),
        .NUM_CHANNELS(4),
        .INPUT_WIDTH(4)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_values(in_values),
        .in_mask(in_mask),
        .out(out),
        .gamma_start(gamma_start),
        .active(active)
    );

    typedef struct {
        logic [15:0] vals;
        logic [3:0]  mask;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    logic cur_valid = 1'b0;

    int tests  = 0;
    int errors = 0;
    int tb_g   = 0;
    int tb_cyc = 0;
    logic staged_exp  = 1'b0;
    logic acc_pending = 1'b0;
    int   acc_g       = 0;
    int   last_due    = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference gamma counter and gamma-cycle index.
    always @(posedge aclk or posedge grst) begin
        if (grst) begin
            tb_g   <= 0;
            tb_cyc <= 0;
        end else if (tb_g == 15) begin
            tb_g   <= 0;
            tb_cyc <= tb_cyc + 1;
        end else begin
            tb_g <= tb_g + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t g=%0d)", name, act, exp, $time, tb_g);
        end
    endtask

    function automatic logic [3:0] model_out(input logic [15:0] vals, input logic [3:0] mask, input int g);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            int v;
            int hi;
            v = int'(vals[i*4 +: 4]);
`ifdef ENC_PULSE_OUT_EN
            hi = v + 3;
`else
            hi = 15;
`endif
            if (hi > 15) hi = 15;
            r[i] = mask[i] && (g >= v) && (g <= hi);
        end
        return r;
    endfunction

    // Monitor: picks the vector due in each gamma cycle and checks every cycle against the model.
    initial begin
        forever begin
            @(negedge aclk);
            if (grst) begin
                cur_valid = 1'b0;
            end else begin
                if (tb_g == 0) begin
                    while (sb_q.size() > 0 && sb_q[0].due < tb_cyc) begin
                        tests++;
                        errors++;
                        $display("FAIL lost_vector: got none expected vals=%0h mask=%0h in cycle %0d",
                                 sb_q[0].vals, sb_q[0].mask, sb_q[0].due);
                        void'(sb_q.pop_front());
                    end
                    if (sb_q.size() > 0 && sb_q[0].due == tb_cyc) begin
                        cur = sb_q.pop_front();
                        cur_valid = 1'b1;
                    end else begin
                        cur_valid = 1'b0;
                    end
                end
                check("gamma_start", gamma_start, tb_g == 0);
                check("active", active, cur_valid);
                check("out", out, cur_valid ? model_out(cur.vals, cur.mask, tb_g) : 4'b0000);
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
        if (acc_pending) begin
            if (acc_g != 15) staged_exp = 1'b1;
            acc_pending = 1'b0;
        end
        if (tb_g == 0) staged_exp = 1'b0;
        if (!grst) check("in_ready", in_ready, !staged_exp);
    endtask

    task automatic wait_g(input int target);
        for (int n = 0; n < 64; n++) begin
            if (tb_g == target) return;
            step();
        end
        check("wait_g_timeout", tb_g, target);
    endtask

    task automatic send(input logic [15:0] vals, input logic [3:0] mask, input logic last);
        exp_t e;
        in_values = vals;
        in_mask   = mask;
        in_valid  = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (in_ready) begin
                e.vals = vals;
                e.mask = mask;
                e.due  = tb_cyc + 1;
                last_due = e.due;
                sb_q.push_back(e);
                acc_pending = 1'b1;
                acc_g = tb_g;
                step();
                if (last) in_valid = 1'b0;
                return;
            end
            step();
        end
        check("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int d1;
        int d2;
        grst      = 1'b1;
        in_valid  = 1'b0;
        in_values = 16'h0000;
        in_mask   = 4'b0000;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_out", out, 4'b0000);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_active", active, 1'b0);
        check("rst_gamma_start", gamma_start, 1'b1);
        grst = 1'b0;
        repeat (40) step();

        // Basic encode: ch0=3 ch1=0 ch2=15 ch3=7 accepted at g=5.
        wait_g(5);
        send({4'd7, 4'd15, 4'd0, 4'd3}, 4'b1111, 1'b1);
        repeat (20) step();

        // Mask / infinity: only ch0 and ch2 fire at g=2.
        wait_g(9);
        send({4'd2, 4'd2, 4'd2, 4'd2}, 4'b0101, 1'b1);
        repeat (20) step();

        // Mixed values including late edges (pulse clipping near the boundary).
        wait_g(1);
        send({4'd14, 4'd12, 4'd5, 4'd0}, 4'b1111, 1'b1);
        repeat (20) step();

        // Backpressure: in_valid held high across three vectors.
        wait_g(3);
        send({4'd12, 4'd8, 4'd4, 4'd1}, 4'b1111, 1'b0);
        d0 = last_due;
        send({4'd10, 4'd5, 4'd0, 4'd15}, 4'b1011, 1'b0);
        d1 = last_due;
        send({4'd6, 4'd6, 4'd6, 4'd6}, 4'b1110, 1'b1);
        d2 = last_due;
        check("burst_order_1", d1, d0 + 1);
        check("burst_order_2", d2, d1 + 1);
        repeat (60) step();

        // Bypass: offer only at g=15 with staging empty.
        wait_g(15);
        send({4'd9, 4'd1, 4'd0, 4'd4}, 4'b1101, 1'b1);
        repeat (40) step();

        // Reset in the middle of an emission of value 13.
        wait_g(4);
        send({4'd0, 4'd0, 4'd0, 4'd13}, 4'b0001, 1'b1);
        for (int n = 0; n < 64; n++) begin
            if (tb_cyc == last_due && tb_g == 14) break;
            step();
        end
        check("pre_reset_out", out, 4'b0001);
        grst = 1'b1;
        #1;
        check("mid_rst_out", out, 4'b0000);
        check("mid_rst_active", active, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        sb_q.delete();
        staged_exp  = 1'b0;
        acc_pending = 1'b0;
        in_valid    = 1'b0;
        repeat (3) step();
        grst = 1'b0;
        repeat (40) step();

        check("queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/enc_b_t_1.md
Name: enc_b_t_1

Overview:
Binary-to-temporal encoder: the transmit end of the race-logic interface whose receiver recovers binary values from rising-edge arrival times.
- Accepts a vector of binary values over a valid/ready handshake.
- In the next gamma cycle, emits one rising edge per channel at the gamma-counter tick equal to that channel's value.
- Drives the temporal inputs of downstream temporal/mux/decoder blocks; the downstream blocks share aclk/grst, so their gamma counters align.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: gamma-cycle length in aclk cycles; counter range 0..GAMMA_CYCLE_WIDTH-1.
- PULSE_WIDTH, 8: high time in cycles of each edge when ENC_PULSE_OUT_EN is defined; legal range 1..GAMMA_CYCLE_WIDTH.
- NUM_CHANNELS, 16: number of independent temporal outputs.
- INPUT_WIDTH, $clog2(GAMMA_CYCLE_WIDTH): width of each binary value.

Ports:
- aclk  input  1  clock.
- grst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer offers a value vector.
- in_ready  output  1  staging slot empty; transfer happens when in_valid && in_ready at a rising aclk edge.
- in_values  input  NUM_CHANNELS*INPUT_WIDTH (packed [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0])  per-channel firing time.
- in_mask  input  NUM_CHANNELS  1 = channel fires; 0 = channel is "infinity", no edge this gamma cycle.
- out  output  NUM_CHANNELS  temporal outputs.
- gamma_start  output  1  high while the gamma counter g==0.
- active  output  1  an active vector is being emitted in the current gamma cycle.

Behaviour:
- Gamma counter g:
  - Registered; reset 0.
  - Increments every cycle; wraps from GAMMA_CYCLE_WIDTH-1 to 0.
  - Must handle non-power-of-2 GAMMA_CYCLE_WIDTH via an explicit compare, not natural overflow.
- Storage: two registers, STAGED (values, mask, full flag) and ACTIVE (values, mask, valid flag). All clear on reset.
- Outputs at reset: in_ready=1, out=0, active=0, gamma_start=1 (g=0).
- in_ready = !staged_full. This is combinational from a register only, never from in_valid.
- Accept: when in_valid && in_ready, STAGED loads in_values/in_mask and sets full on that edge.
- Promotion on the boundary edge (g==GAMMA_CYCLE_WIDTH-1 -> 0):
  - If staged_full: ACTIVE <= STAGED, active_valid <= 1, staged_full <= 0.
  - Else if an accept occurs in that same cycle (staging empty, so in_ready=1): the accepted vector bypasses STAGED and loads ACTIVE directly; staged_full stays 0.
  - Else: active_valid <= 0, so the next gamma cycle is silent.
- No mid-cycle change: ACTIVE changes only on the boundary edge. A vector accepted mid-cycle waits in STAGED and is emitted in the following gamma cycle.
- Throughput: one vector per gamma cycle. Back-to-back producers see in_ready low from acceptance until the boundary edge.
- Output generation:
  - out is registered, computed from next-state g and ACTIVE, so out[i] is aligned with g in the same cycle and is glitch-free.
  - Default (step) mode: out[i]=1 in cycles where active_valid && mask[i] && g >= value[i].
  - Values >= GAMMA_CYCLE_WIDTH never fire.
  - out[i] falls to 0 at g==0 of the next gamma cycle, so every gamma cycle starts with all outputs low.
  - Value 0 fires in the g==0 cycle, so it is distinguishable from "no edge" only by in_mask.
- active = active_valid (registered). gamma_start = (g==0).
- Reset mid-operation: all state clears asynchronously; out drops immediately; any staged or active vector is discarded. After grst deasserts, g restarts at 0.

Optional Feature:
Macro ENC_PULSE_OUT_EN.
- Defined: out[i]=1 only for value[i] <= g <= min(value[i]+PULSE_WIDTH-1, GAMMA_CYCLE_WIDTH-1). Pulses are clipped at the gamma boundary and never wrap into the next cycle. Sum computed at INPUT_WIDTH+$clog2(PULSE_WIDTH)+1 bits to avoid overflow.
- Undefined: step behaviour as above. PULSE_WIDTH unused.

Test Plan:
(All scenarios use GAMMA_CYCLE_WIDTH=16, NUM_CHANNELS=4.)
- Reset check: assert grst, then release -> out=0, in_ready=1, active=0, and gamma_start pulses every 16 cycles starting at g=0.
- Basic encode: values {3,0,15,7}, mask 4'b1111, accepted at g=5 -> next gamma cycle: out[1] rises at g=0, out[0] at g=3, out[3] at g=7, out[2] at g=15; all out low at following g=0; active high exactly those 16 cycles.
- Mask and infinity: mask 4'b0101, values {2,2,2,2} -> only out[0], out[2] rise at g=2; out[1], out[3] stay 0.
- Backpressure: in_valid held high with 3 distinct vectors -> in_ready low from first acceptance until boundary; vectors emitted in 3 consecutive gamma cycles in order, none lost or duplicated.
- Bypass: in_valid asserted only at g=15 with staging empty -> accepted and emitted in the gamma cycle starting next edge; staged_full never set.
- Reset mid-cycle plus pulse mode: with ENC_PULSE_OUT_EN and PULSE_WIDTH=4, value 13 -> out high g=13..15 only (clipped). Assert grst at g=14 -> out=0 immediately; no emission after release until a new accept.
